// File: rtl/pattern_serializer.sv
// pattern_serializer: loads a parallel test pattern and shifts it out MSB-first
// on ser_out, one bit per tick, with a ser_strobe pulse marking each valid bit.
// Ticks come from an internal DIV-cycle prescaler or from rising edges of a
// manual step input. Loop mode replays the pattern without a gap bit.
module pattern_serializer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic             loop_mode,
  input  logic             step_mode,
  input  logic             step,
  output logic             ser_out,
  output logic             ser_strobe,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_hold;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_eff;
  logic [PW-1:0]    r_presc;
  logic             r_step_d;
  logic             r_loop;

  logic [LEN_W-1:0] w_len_eff;
  logic [WIDTH-1:0] w_load;
  logic             w_tick;
  logic             w_fire;

  // Effective length and left-aligned pattern so the first bit sits at the MSB.
  always_comb begin
    w_len_eff = len;
    if (len == '0 || len > LEN_MAX) begin
      w_len_eff = LEN_MAX;
    end
    w_load = data << (LEN_MAX - w_len_eff);
  end

  // Tick source: prescaler wrap in auto mode, step rising edge in step mode
  // (step_mode is live so the source can be switched mid-run).
  always_comb begin
    w_tick = step_mode ? (step & ~r_step_d) : (r_presc == PRESC_LAST);
    w_fire = (r_state == S_SHIFT) && w_tick && !abort;
  end

  // Outputs decoded from registered state; abort and reset suppress pulses.
  always_comb begin
    busy       = (r_state == S_SHIFT);
    ser_out    = busy & r_shreg[WIDTH-1];
    remaining  = busy ? r_cnt : '0;
    ser_strobe = w_fire & ~reset;
    done       = (r_state == S_DONE) & ~abort & ~reset;
  end

  // Control FSM with shift register, bit counter and prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_len_eff <= '0;
      r_presc   <= '0;
      r_step_d  <= 1'b0;
      r_loop    <= 1'b0;
    end else begin
      r_step_d <= step;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_hold    <= w_load;
            r_shreg   <= w_load;
            r_cnt     <= w_len_eff;
            r_len_eff <= w_len_eff;
            r_loop    <= loop_mode;
            r_presc   <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_presc <= '0;
            r_state <= S_IDLE;
          end else begin
            if (step_mode || r_presc == PRESC_LAST) begin
              r_presc <= '0;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
            if (w_tick) begin
              if (r_cnt == LEN_W'(1)) begin
                if (r_loop) begin
                  r_shreg <= r_hold;
                  r_cnt   <= r_len_eff;
                end else begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
                end
              end else begin
                r_shreg <= r_shreg << 1;
                r_cnt   <= r_cnt - 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
